// File: rtl/reg_share_arbiter.sv
// Round-robin owner of one shared WIDTH-bit holding register: grants, steers data,
// pulses the load enable, holds ownership for HOLD_CYC cycles and acknowledges.
module reg_share_arbiter #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int HOLD_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] din,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic                  ld_en,
    output logic [WIDTH-1:0]      reg_d,
    output logic                  busy
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     own_q, own_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              ld_en_q, ld_en_d;
    logic [WIDTH-1:0]  reg_d_q, reg_d_d;
    logic              busy_q, busy_d;

    logic              found;
    logic [PW-1:0]     pick;
    int                idx;

    // First requester at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        ld_en_d = 1'b0;
        reg_d_d = reg_d_q;

        case (state_q)
            IDLE: begin
                gnt_d   = '0;
                reg_d_d = '0;
                if (found) begin
                    state_d     = GRANT;
                    own_d       = pick;
                    gnt_d[pick] = 1'b1;
                    ld_en_d     = 1'b1;
                    reg_d_d     = din[pick*WIDTH +: WIDTH];
                end
            end
            GRANT: begin
                // The pointer moves past the owner even when the grant is aborted.
                ptr_d = (int'(own_q) == NREQ - 1) ? '0 : own_q + 1'b1;
                if (!req[own_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    reg_d_d = '0;
                end else begin
                    state_d = HOLD;
                    cnt_d   = CW'(HOLD_CYC - 1);
                    if (HOLD_CYC == 1) begin
                        ack_d = gnt_q;
                    end
                end
            end
            HOLD: begin
                if (!req[own_q] || cnt_q == '0) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    reg_d_d = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    // Registered ack lands in the final HOLD cycle.
                    if (cnt_q == CW'(1)) begin
                        ack_d = gnt_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                reg_d_d = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            own_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            ld_en_q <= 1'b0;
            reg_d_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            ld_en_q <= ld_en_d;
            reg_d_q <= reg_d_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt   = gnt_q;
    assign ack   = ack_q;
    assign ld_en = ld_en_q;
    assign reg_d = reg_d_q;
    assign busy  = busy_q;

endmodule
